// File: rtl/video_pkg.sv
// Shared definitions for the video fill/blit DMA: register map, CTRL bits, FSM states.
package video_pkg;

    localparam int unsigned MAP_BITS = 6;
    localparam int unsigned IDX_BITS = 2 * MAP_BITS;

    localparam logic [31:0] VIDEO_TILE_BASE = 32'h0520_0000;
    localparam logic [31:0] VIDEO_TEX_BASE  = 32'h0510_0000;

    localparam logic [1:0] REG_BASE = 2'd0;
    localparam logic [1:0] REG_RECT = 2'd1;
    localparam logic [1:0] REG_DATA = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int unsigned CTRL_START    = 0;
    localparam int unsigned CTRL_CLR_DONE = 1;
    localparam int unsigned CTRL_INC      = 2;
    localparam int unsigned STAT_BUSY     = 0;
    localparam int unsigned STAT_DONE     = 1;

    localparam logic [31:0] RECT_MASK = 32'h7F7F_3F3F;

    typedef struct packed {
        logic                rsv3;
        logic [MAP_BITS:0]   h;
        logic                rsv2;
        logic [MAP_BITS:0]   w;
        logic [1:0]          rsv1;
        logic [MAP_BITS-1:0] y0;
        logic [1:0]          rsv0;
        logic [MAP_BITS-1:0] x0;
    } rect_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } fill_state_e;

    // Byte-strobe merge of a register write.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/video_fill_walker.sv
// Rectangle walker: x/y cell counters with independent modulo-64 wrap, row/column countdown.
module video_fill_walker
    import video_pkg::*;
#(
    parameter int unsigned MAP_BITS_P = MAP_BITS
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      load,
    input  logic                      step,
    input  logic [MAP_BITS_P-1:0]     x0,
    input  logic [MAP_BITS_P-1:0]     y0,
    input  logic [MAP_BITS_P:0]       w,
    input  logic [MAP_BITS_P:0]       h,
    output logic [2*MAP_BITS_P-1:0]   idx_c,
    output logic                      last_c
);

    localparam int unsigned CNT_BITS = MAP_BITS_P + 1;

    logic [MAP_BITS_P-1:0] cx_q, cy_q, x0_q, cx_d, cy_d, x0_d;
    logic [CNT_BITS-1:0]   rows_q, cols_q, w_q, rows_d, cols_d, w_d;

    // Next counter values; idx_c is the cell the counters will point at after this edge.
    always_comb begin
        cx_d   = cx_q;
        cy_d   = cy_q;
        rows_d = rows_q;
        cols_d = cols_q;
        x0_d   = x0_q;
        w_d    = w_q;
        if (load) begin
            cx_d   = x0;
            cy_d   = y0;
            rows_d = h;
            cols_d = w;
            x0_d   = x0;
            w_d    = w;
        end else if (step) begin
            if (cols_q == CNT_BITS'(1)) begin
                cx_d   = x0_q;
                cy_d   = cy_q + MAP_BITS_P'(1);
                rows_d = rows_q - CNT_BITS'(1);
                cols_d = w_q;
            end else begin
                cx_d   = cx_q + MAP_BITS_P'(1);
                cols_d = cols_q - CNT_BITS'(1);
            end
        end
    end

    assign idx_c  = {cy_d, cx_d};
    assign last_c = (rows_q == CNT_BITS'(1)) && (cols_q == CNT_BITS'(1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cx_q   <= '0;
            cy_q   <= '0;
            rows_q <= '0;
            cols_q <= '0;
            x0_q   <= '0;
            w_q    <= '0;
        end else begin
            cx_q   <= cx_d;
            cy_q   <= cy_d;
            rows_q <= rows_d;
            cols_q <= cols_d;
            x0_q   <= x0_d;
            w_q    <= w_d;
        end
    end

endmodule

// File: rtl/video_fill_dma.sv
// Video fill/blit engine: CPU-programmed rectangle fill issued as one master write per cell.
// Optional VIDEO_FILL_DMA_PATTERN_INC_EN adds CTRL.INC (write data increments per beat).
module video_fill_dma
    import video_pkg::*;
#(
    parameter logic [31:0] DEFAULT_BASE = VIDEO_TILE_BASE
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [3:0]  s_wstrb,
    input  logic [31:0] s_addr,
    input  logic [31:0] s_wdata,
    output logic [31:0] s_rdata,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic        busy,
    output logic        irq
);

    fill_state_e state_q, state_d;

    logic [31:0]         base_q, data_q, wbase_q;
    rect_t               rect_q;
    logic                done_q, done_d, winc_q, inc_q, start_inc;
    logic                acc, ctrl_wr, start, clr, fire;
    logic                load, step, set_done, last_c;
    logic [IDX_BITS-1:0] idx_c;
    logic [1:0]          sel;
    logic                unused_addr_bits;

    assign sel              = s_addr[3:2];
    assign unused_addr_bits = ^{s_addr[31:4], s_addr[1:0]};
    assign acc              = s_valid && !s_ready;
    assign ctrl_wr          = acc && s_wstrb[0] && (sel == REG_CTRL);
    assign start            = ctrl_wr && s_wdata[CTRL_START];
    assign clr              = ctrl_wr && s_wdata[CTRL_CLR_DONE];
    assign fire             = m_valid && m_ready;
    assign done_d           = set_done || (done_q && !clr);

`ifdef VIDEO_FILL_DMA_PATTERN_INC_EN
    assign start_inc = s_wdata[CTRL_INC];
    always_ff @(posedge clk) begin
        if (!resetn)      inc_q <= 1'b0;
        else if (ctrl_wr) inc_q <= s_wdata[CTRL_INC];
    end
`else
    assign start_inc = 1'b0;
    assign inc_q     = 1'b0;
`endif

    video_fill_walker #(.MAP_BITS_P(MAP_BITS)) u_walker (
        .clk    (clk),
        .resetn (resetn),
        .load   (load),
        .step   (step),
        .x0     (rect_q.x0),
        .y0     (rect_q.y0),
        .w      (rect_q.w),
        .h      (rect_q.h),
        .idx_c  (idx_c),
        .last_c (last_c)
    );

    always_ff @(posedge clk) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next state and per-cycle controls; START is only honoured from IDLE.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        step     = 1'b0;
        set_done = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = (rect_q.w == '0 || rect_q.h == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (fire) begin
                    step = 1'b1;
                    if (last_c) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                set_done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s_ready <= 1'b0;
            s_rdata <= '0;
            m_valid <= 1'b0;
            m_wstrb <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
            busy    <= 1'b0;
            irq     <= 1'b0;
            done_q  <= 1'b0;
            base_q  <= DEFAULT_BASE;
            rect_q  <= '0;
            data_q  <= '0;
            wbase_q <= '0;
            winc_q  <= 1'b0;
        end else begin
            s_ready <= acc;
            done_q  <= done_d;
            irq     <= done_d;
            busy    <= (state_d != ST_IDLE);
            m_valid <= (state_d == ST_ISSUE);
            m_wstrb <= (state_d == ST_ISSUE) ? 4'hF : 4'h0;

            s_rdata <= '0;
            if (acc) begin
                unique case (sel)
                    REG_BASE: s_rdata <= base_q;
                    REG_RECT: s_rdata <= rect_q;
                    REG_DATA: s_rdata <= data_q;
                    REG_CTRL: s_rdata <= {29'b0, inc_q, done_q, busy};
                endcase
                if (sel == REG_BASE) base_q <= apply_strb(base_q, s_wdata, s_wstrb);
                if (sel == REG_RECT) rect_q <= apply_strb(rect_q, s_wdata, s_wstrb) & RECT_MASK;
                if (sel == REG_DATA) data_q <= apply_strb(data_q, s_wdata, s_wstrb);
            end

            if (load) begin
                wbase_q <= base_q;
                winc_q  <= start_inc;
            end
            // Next address is registered so back-to-back beats need no bubble.
            if (load || (step && !last_c))
                m_addr <= (load ? base_q : wbase_q) + 32'({idx_c, 2'b00});
            if (load)                m_wdata <= data_q;
            else if (step && winc_q) m_wdata <= m_wdata + 32'd1;
        end
    end

endmodule
